// File: rtl/bn_relu_pool_pkg.sv
// Shared types, sizing defaults and helper functions for the BN / ReLU / pool / conv datapath.
package bn_relu_pool_pkg;

  localparam int D_WL_DEF  = 24;
  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;

  localparam int HALF_W = IMG_W_DEF / 2;
  localparam int COL_W  = $clog2(IMG_W_DEF);
  localparam int ROW_W  = $clog2(IMG_H_DEF);

  // Negative BN results clamp to zero; the result is then treated as unsigned.
  function automatic logic [D_WL_DEF-1:0] relu(input logic signed [D_WL_DEF-1:0] x);
    logic [D_WL_DEF-1:0] r;
    r = x[D_WL_DEF-1] ? '0 : x;
    return r;
  endfunction

  function automatic logic [D_WL_DEF-1:0] umax(input logic [D_WL_DEF-1:0] a,
                                               input logic [D_WL_DEF-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/bn_relu_pool_line_buf.sv
// Half-row line buffer holding the even-row horizontal pair maxima; combinational read
// so the pooled result is registered one cycle after the window's last pixel.
module pool_line_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bn_relu_pool.sv
// ReLU followed by 2x2 / stride-2 max-pooling over a raster-order BN pixel stream.
// The stream cannot be stalled, so every path accepts a pixel on any cycle.
import bn_relu_pool_pkg::*;

module bn_relu_pool #(
  parameter int D_WL  = D_WL_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [D_WL-1:0] D_IN,
  input  logic            in_valid,
  input  logic            frame_start,
  output logic [D_WL-1:0] D_O,
  output logic            o_valid,
  output logic            frame_done
);

  localparam int LB_DEPTH = IMG_W / 2;
  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic signed [D_WL-1:0] d_in_s;
  logic [D_WL-1:0]        r_p0;
  logic [D_WL-1:0]        pair_p0;
  logic [D_WL-1:0]        hmax_p0;
  logic [D_WL-1:0]        lb_rd_p0;
  logic [D_WL-1:0]        wmax_p0;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic [AW-1:0] lb_addr;
  logic          lb_we;
  logic          win_done;
  logic          last_win;

  logic [D_WL-1:0] d_o_p1;
  logic            vld_p1;
  logic            done_p1;

  // Stage p0: ReLU, horizontal pair max, vertical max against the line buffer.
  // A frame_start coinciding with a pixel forces that pixel to position (0,0).
  assign d_in_s   = D_IN;
  assign r_p0     = relu(d_in_s);
  assign col_eff  = frame_start ? '0 : col;
  assign row_eff  = frame_start ? '0 : row;
  assign lb_addr  = AW'(col_eff >> 1);
  assign hmax_p0  = umax(pair_p0, r_p0);
  assign wmax_p0  = umax(hmax_p0, lb_rd_p0);
  assign lb_we    = in_valid & col_eff[0] & ~row_eff[0];
  assign win_done = in_valid & col_eff[0] & row_eff[0];
  assign last_win = (col_eff == COL_LAST) && (row_eff == ROW_LAST);

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (D_WL),
    .AW    (AW)
  ) u_line_buf (
    .CLK     (CLK),
    .we      (lb_we),
    .wr_addr (lb_addr),
    .wr_data (hmax_p0),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_p0)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      pair_p0 <= '0;
    end else if (in_valid) begin
      if (!col_eff[0]) pair_p0 <= r_p0;
      if (col_eff == COL_LAST) begin
        col <= '0;
        row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // Stage p1: registered pooled output; D_O holds between strobes.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      d_o_p1  <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= win_done;
      done_p1 <= win_done & last_win;
      if (win_done) d_o_p1 <= wmax_p0;
    end
  end

  assign D_O        = d_o_p1;
  assign o_valid    = vld_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_bn_relu_pool.sv
// Directed scoreboard bench for bn_relu_pool on a 4x2 image: stimulus pushes the
// hand-computed pooled result, a negedge monitor pops and compares on each strobe.
module tb_bn_relu_pool;

  localparam int D_WL  = 24;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;

  logic            CLK = 1'b0;
  logic            rst_n;
  logic [D_WL-1:0] D_IN;
  logic            in_valid;
  logic            frame_start;
  logic [D_WL-1:0] D_O;
  logic            o_valid;
  logic            frame_done;

  typedef struct {
    logic [D_WL-1:0] d;
    logic            done;
    int              cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bn_relu_pool #(.D_WL(D_WL), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .D_IN        (D_IN),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .D_O         (D_O),
    .o_valid     (o_valid),
    .frame_done  (frame_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (rst_n === 1'b1) begin
      if (o_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe actual=%0h required=no strobe", D_O);
        end else begin
          e = sbq.pop_front();
          chk("pool_data", 32'(D_O), 32'(e.d));
          chk("frame_done", 32'(frame_done), 32'(e.done));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (frame_done === 1'b1) begin
        total++;
        bad++;
        $display("FAIL done_without_valid actual=1 required=0");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_valid    = 1'b0;
      frame_start = 1'b0;
      D_IN        = '0;
    end
  endtask

  task automatic pix(input int v, input bit fs = 1'b0, input bit eo = 1'b0,
                     input int ed = 0, input bit edn = 1'b0);
    exp_t x;
    @(negedge CLK);
    D_IN        = D_WL'(v);
    in_valid    = 1'b1;
    frame_start = fs;
    if (eo) begin
      x.d    = D_WL'(ed);
      x.done = edn;
      x.cyc  = cyc + 1;
      sbq.push_back(x);
    end
  endtask

  task automatic gpix(input int v, input bit eo = 1'b0, input int ed = 0, input bit edn = 1'b0);
    idle($urandom_range(0, 3));
    pix(v, 1'b0, eo, ed, edn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; D_IN = '0;
    repeat (3) @(negedge CLK);
    chk("reset_D_O", 32'(D_O), 0);
    chk("reset_o_valid", 32'(o_valid), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    rst_n = 1'b1;

    // Basic frame, back-to-back.
    pix(1); pix(-5); pix(7); pix(3);
    pix(2); pix(4, 0, 1, 4, 0); pix(-1); pix(-9, 0, 1, 7, 1);
    idle(2);

    // Same frame with random gaps.
    gpix(1); gpix(-5); gpix(7); gpix(3);
    gpix(2); gpix(4, 1, 4, 0); gpix(-1); gpix(-9, 1, 7, 1);
    idle(2);

    // All negative inputs.
    pix(-32'h800000); pix(-1); pix(-32'h800000); pix(-1);
    pix(-1); pix(-32'h800000, 0, 1, 0, 0); pix(-2); pix(-1, 0, 1, 0, 1);
    idle(1);

    // Max positive via line-buffer path (window 0) and current-row path (window 1).
    pix(0); pix(32'h7FFFFF); pix(0); pix(0);
    pix(0); pix(0, 0, 1, 32'h7FFFFF, 0); pix(32'h7FFFFF); pix(0, 0, 1, 32'h7FFFFF, 1);
    idle(1);

    // Abort mid-row-1 with frame_start on an idle cycle, then a fresh frame.
    pix(10); pix(20); pix(30); pix(40);
    pix(50); pix(60, 0, 1, 60, 0); pix(70);
    @(negedge CLK); in_valid = 1'b0; frame_start = 1'b1; D_IN = '0;
    idle(1);
    pix(0); pix(1); pix(2); pix(3);
    pix(4); pix(5, 0, 1, 5, 0); pix(6); pix(7, 0, 1, 7, 1);
    idle(2);

    // frame_start coinciding with a valid pixel restarts at (0,0).
    pix(100); pix(100);
    pix(1, 1); pix(2); pix(3); pix(4);
    pix(5); pix(6, 0, 1, 6, 0); pix(7); pix(8, 0, 1, 8, 1);
    idle(2);

    // Asynchronous reset mid-frame while a strobe is showing.
    pix(1); pix(2); pix(3); pix(4); pix(5); pix(6);
    @(posedge CLK); #1;
    chk("pre_reset_o_valid", 32'(o_valid), 1);
    chk("pre_reset_D_O", 32'(D_O), 6);
    #1 rst_n = 1'b0; in_valid = 1'b0; D_IN = '0;
    #1;
    chk("async_reset_D_O", 32'(D_O), 0);
    chk("async_reset_o_valid", 32'(o_valid), 0);
    chk("async_reset_frame_done", 32'(frame_done), 0);
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    pix(1); pix(2); pix(3); pix(4);
    pix(5); pix(6, 0, 1, 6, 0); pix(7); pix(8, 0, 1, 8, 1);
    idle(4);

    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bn_relu_pool.md
Name: bn_relu_pool

Overview:
- Stage directly downstream of batch-norm. It consumes the serial per-pixel BN output stream (data plus 1-bit valid) of one feature-map channel in raster order.
- Applies ReLU, then 2x2 / stride-2 max-pooling, using a half-row line buffer.
- Emits one pooled pixel per 2x2 window, with a valid strobe and a frame-done pulse, to the next binary-weight conv layer's input buffer.
- No backpressure: the upstream stream cannot be stalled, so this block must accept a pixel on any cycle.

Parameters:
- D_WL, 24, data word length (signed two's complement, same format as BN output).
- IMG_W, 32, input row width in pixels; must be even and at least 2.
- IMG_H, 32, input rows per frame; must be even and at least 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- D_IN  input  D_WL  signed BN result; sampled only when in_valid=1.
- in_valid  input  1  D_IN holds a valid pixel this cycle (driven from BN's output-valid).
- frame_start  input  1  synchronous restart: resets the row/column position to (0,0).
- D_O  output  D_WL  pooled pixel, always >= 0.
- o_valid  output  1  D_O is valid this cycle (single-cycle strobe per window).
- frame_done  output  1  one-cycle pulse, coincident with the o_valid of the last window of a frame.

Behaviour:
- Reset (rst_n=0, asynchronous): D_O=0, o_valid=0, frame_done=0; col=0, row=0; pair register=0. Line-buffer contents are don't-care.
- ReLU on every accepted pixel: r = D_IN[D_WL-1] ? 0 : D_IN. All later compares are unsigned on non-negative values.
- Position counters advance only on in_valid=1.
  - col counts 0..IMG_W-1; wrapping from IMG_W-1 to 0 increments row.
  - row counts 0..IMG_H-1; wrapping from IMG_H-1 to 0 starts the next frame automatically.
  - Idle cycles (in_valid=0) hold all state; gaps of any length are allowed between pixels.
- Even column (col[0]=0): pair register <= r.
- Odd column (col[0]=1): m = max(pair, r).
  - Even row: line_buf[col>>1] <= m. No output.
  - Odd row: D_O <= max(m, line_buf[col>>1]) and o_valid <= 1 on the next edge. Latency: one cycle after the window's last pixel.
- o_valid and frame_done deassert on the following cycle unless a new window completes. D_O holds its last value between strobes.
- frame_done <= 1 when the completing pixel has row=IMG_H-1 and col=IMG_W-1.
- frame_start=1 with in_valid=1: the pixel is treated as (0,0) and processed normally; counters then become col=1, row=0.
- frame_start=1 with in_valid=0: col=0, row=0, pair unchanged. A window in progress is abandoned and its output never appears.
- frame_start does not suppress an o_valid already registered from the previous cycle.
- Max ties: either operand may be selected; the results are identical.
- Line buffer: IMG_W/2 words of D_WL bits, single write and single read per cycle, read address = write address = col>>1. A register array or a synchronous-read RAM is acceptable, provided the one-cycle output latency holds.
- Throughput: one pixel per cycle sustained; output rate is one per four input pixels on average.

Decomposition:
- Shared package, reused by conv and BN:
  - default D_WL=24.
  - function relu(signed word).
  - function umax(a,b).
  - localparams HALF_W=IMG_W/2, COL_W=$clog2(IMG_W), ROW_W=$clog2(IMG_H).
- One natural sub-module: pool_line_buf. It is a parameterised HALF_W x D_WL storage with write-enable, write address, and read address, so it can later be swapped for a RAM macro.
- Counters, ReLU, compare and output registers stay in the top level.

Test Plan:
- IMG_W=4, IMG_H=2; rows {1,-5,7,3} then {2,4,-1,-9}, back-to-back valid. Required: o_valid on two cycles, one after pixel (1,1) with D_O=4 and one after pixel (1,3) with D_O=7; frame_done together with the second strobe.
- Same frame with in_valid=0 gaps of 0-3 cycles randomly inserted. Required: identical D_O sequence {4,7}, each strobe exactly one cycle after its completing pixel.
- Frame where all inputs are negative (e.g. -0x800000, -1). Required: every output D_O=0 with o_valid=1.
- Max-magnitude positive input 0x7FFFFF in one window position, rest 0. Required: D_O=0x7FFFFF with no sign corruption.
- Assert frame_start with in_valid=0 after 3 pixels of row 1, then send a full new frame {0,1,2,3},{4,5,6,7}. Required: outputs {5,7}, no stale output from the aborted frame, frame_done at the end.
- Drop rst_n mid-frame for one cycle, asynchronously between clock edges. Required: D_O, o_valid and frame_done go to 0 immediately; the next full frame pools correctly from (0,0).
